// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: reset/handler addresses, ExcCodes, fetch FSM encoding.
package fetch_ctrl_pkg;

    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDR  = 32'h0000_4180;
    localparam int unsigned IM_DEPTH      = 2048;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_ERR_WAIT = 1'b1
    } fetch_state_e;

    // Misaligned or outside [lo, hi) is an instruction-fetch address error.
    function automatic logic addr_error(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc >= hi);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: pipeline controls and redirects in, instruction memory and IF/ID contents out.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic         stall;
    logic         flush;
    logic         br_taken;
    logic [31:0]  br_target;
    logic         exc_req;
    logic         eret;
    logic [31:0]  epc;
    logic [31:0]  im_addr;
    logic [31:0]  im_data;
    logic [31:0]  instr_D;
    logic [31:0]  pc_D;
    logic [31:0]  pc8_D;
    logic         valid_D;
    logic         exc_D;
    logic [4:0]   exccode_D;
    logic [31:0]  fetch_count;
    fetch_state_e state;

    // Control inputs are level-sampled on every rising edge; there is no
    // valid/ready handshake, stall is the only back-pressure into fetch.
    modport slave (
        input  stall, flush, br_taken, br_target, exc_req, eret, epc, im_data,
        output im_addr, instr_D, pc_D, pc8_D, valid_D, exc_D, exccode_D,
               fetch_count, state
    );

    modport master (
        output stall, flush, br_taken, br_target, exc_req, eret, epc, im_data,
        input  im_addr, instr_D, pc_D, pc8_D, valid_D, exc_D, exccode_D,
               fetch_count, state
    );

endinterface

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register with bubble > hold > load priority.
module if_id_reg
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_bubble,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic        i_exc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc8,
    output logic        o_valid,
    output logic        o_exc,
    output logic [4:0]  o_exccode
);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_instr   <= 32'd0;
            o_pc      <= 32'd0;
            o_pc8     <= 32'd0;
            o_valid   <= 1'b0;
            o_exc     <= 1'b0;
            o_exccode <= EXC_NONE;
        end else if (i_bubble) begin
            // A bubble keeps the last pc_D/pc8_D; only the payload is killed.
            o_instr   <= 32'd0;
            o_valid   <= 1'b0;
            o_exc     <= 1'b0;
            o_exccode <= EXC_NONE;
        end else if (!i_hold && i_load) begin
            o_instr   <= i_exc ? 32'd0 : i_instr;
            o_pc      <= i_pc;
            o_pc8     <= i_pc + 32'd8;
            o_valid   <= 1'b1;
            o_exc     <= i_exc;
            o_exccode <= i_exc ? EXC_ADEL : EXC_NONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch control: PC sequencing, address-error wait FSM and good-fetch counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_ADDR,
    parameter logic [31:0] HANDLER_PC = HANDLER_ADDR,
    parameter int unsigned IM_WORDS   = IM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    fetch_ctrl_if.slave bus
);

    localparam logic [31:0] WIN_END = PC_RESET + (32'(IM_WORDS) << 2);

    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;
    fetch_state_e r_state;

    logic [31:0]  w_next_pc;
    fetch_state_e w_next_state;
    logic         w_addr_err;
    logic         w_bubble;
    logic         w_hold;
    logic         w_load;
    logic         w_err_load;
    logic         w_good_load;
    logic         w_redirect;

    assign w_addr_err = addr_error(r_pc, PC_RESET, WIN_END);
    assign w_redirect = bus.exc_req | bus.eret | bus.br_taken;

    always_comb begin
        w_next_pc    = r_pc;
        w_next_state = r_state;
        w_bubble     = 1'b0;
        w_hold       = 1'b0;
        w_load       = 1'b0;
        w_err_load   = 1'b0;
        w_good_load  = 1'b0;

        if (bus.exc_req | bus.eret | bus.flush) begin
            w_bubble = 1'b1;
        end else if (bus.stall) begin
            w_hold = 1'b1;
        end else if (r_state == ST_ERR_WAIT) begin
            w_bubble = 1'b1;
        end else begin
            w_load      = 1'b1;
            w_err_load  = w_addr_err;
            w_good_load = ~w_addr_err;
        end

        // An error fetch freezes the PC instead of advancing past it.
        if (bus.exc_req) begin
            w_next_pc = HANDLER_PC;
        end else if (bus.eret) begin
            w_next_pc = bus.epc;
        end else if (bus.br_taken) begin
            w_next_pc = bus.br_target;
        end else if (bus.stall) begin
            w_next_pc = r_pc;
        end else if (r_state == ST_RUN && !(w_addr_err && !bus.flush)) begin
            w_next_pc = r_pc + 32'd4;
        end

        case (r_state)
            ST_RUN:      if (w_err_load) w_next_state = ST_ERR_WAIT;
            ST_ERR_WAIT: if (w_redirect) w_next_state = ST_RUN;
            default:     w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_state       <= ST_RUN;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc    <= w_next_pc;
            r_state <= w_next_state;
            if (w_good_load) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .reset     (reset),
        .i_bubble  (w_bubble),
        .i_hold    (w_hold),
        .i_load    (w_load),
        .i_exc     (w_err_load),
        .i_instr   (bus.im_data),
        .i_pc      (r_pc),
        .o_instr   (bus.instr_D),
        .o_pc      (bus.pc_D),
        .o_pc8     (bus.pc8_D),
        .o_valid   (bus.valid_D),
        .o_exc     (bus.exc_D),
        .o_exccode (bus.exccode_D)
    );

    assign bus.im_addr     = r_pc;
    assign bus.fetch_count = r_fetch_count;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one vector per clock edge, all outputs compared.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         rst, stall, flush, br;
        logic [31:0]  tgt;
        logic         exc, eret;
        logic [31:0]  epc, data;
        logic [31:0]  e_im, e_instr, e_pc, e_pc8;
        logic         e_valid, e_exc;
        logic [4:0]   e_ec;
        logic [31:0]  e_fc;
        fetch_state_e e_st;
    } vec_t;

    vec_t vecs[$];
    int   n_vectors = 0;
    int   n_checks = 0;
    int   n_miscompares = 0;

    function automatic vec_t mk(
        input logic rst, input logic stall, input logic flush, input logic br,
        input logic [31:0] tgt, input logic exc, input logic eret,
        input logic [31:0] epc, input logic [31:0] data,
        input logic [31:0] e_im, input logic [31:0] e_instr,
        input logic [31:0] e_pc, input logic [31:0] e_pc8,
        input logic e_valid, input logic e_exc, input logic [4:0] e_ec,
        input logic [31:0] e_fc, input fetch_state_e e_st);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.tgt = tgt;
        v.exc = exc; v.eret = eret; v.epc = epc; v.data = data;
        v.e_im = e_im; v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc8 = e_pc8;
        v.e_valid = e_valid; v.e_exc = e_exc; v.e_ec = e_ec; v.e_fc = e_fc; v.e_st = e_st;
        return v;
    endfunction

    task automatic check32(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL vec%0d %s: got %h, want %h", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        bus.stall     = v.stall;
        bus.flush     = v.flush;
        bus.br_taken  = v.br;
        bus.br_target = v.tgt;
        bus.exc_req   = v.exc;
        bus.eret      = v.eret;
        bus.epc       = v.epc;
        bus.im_data   = v.data;
        @(posedge clk);
        #1;
        n_vectors++;
        check32(idx, "im_addr",     bus.im_addr,         v.e_im);
        check32(idx, "instr_D",     bus.instr_D,         v.e_instr);
        check32(idx, "pc_D",        bus.pc_D,            v.e_pc);
        check32(idx, "pc8_D",       bus.pc8_D,           v.e_pc8);
        check32(idx, "valid_D",     32'(bus.valid_D),    32'(v.e_valid));
        check32(idx, "exc_D",       32'(bus.exc_D),      32'(v.e_exc));
        check32(idx, "exccode_D",   32'(bus.exccode_D),  32'(v.e_ec));
        check32(idx, "fetch_count", bus.fetch_count,     v.e_fc);
        check32(idx, "state",       32'(bus.state),      32'(v.e_st));
    endtask

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'd0;
        bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = 32'd0; bus.im_data = 32'd0;

        //              rst stl fls br  tgt           exc ert epc           data            im            instr         pc            pc8           v  e  ec    fc      state
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h3000, 32'h0,        32'h0,    32'h0,    0, 0, 5'd0, 32'd0,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000000, 32'h3004, 32'h24000000, 32'h3000, 32'h3008, 1, 0, 5'd0, 32'd1,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000001, 32'h3008, 32'h24000001, 32'h3004, 32'h300C, 1, 0, 5'd0, 32'd2,  ST_RUN));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000002, 32'h3008, 32'h24000001, 32'h3004, 32'h300C, 1, 0, 5'd0, 32'd2,  ST_RUN));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000002, 32'h3008, 32'h24000001, 32'h3004, 32'h300C, 1, 0, 5'd0, 32'd2,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000002, 32'h300C, 32'h24000002, 32'h3008, 32'h3010, 1, 0, 5'd0, 32'd3,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000003, 32'h3010, 32'h24000003, 32'h300C, 32'h3014, 1, 0, 5'd0, 32'd4,  ST_RUN));
        // branch under stall redirects the PC but IF/ID holds
        vecs.push_back(mk(0, 1, 0, 1, 32'h3100,     0, 0, 32'h0,        32'h24000004, 32'h3100, 32'h24000003, 32'h300C, 32'h3014, 1, 0, 5'd0, 32'd4,  ST_RUN));
        vecs.push_back(mk(0, 0, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h11111111, 32'h3200, 32'h0,        32'h300C, 32'h3014, 0, 0, 5'd0, 32'd4,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3102,     0, 0, 32'h0,        32'h22222222, 32'h3102, 32'h22222222, 32'h3200, 32'h3208, 1, 0, 5'd0, 32'd5,  ST_RUN));
        // misaligned fetch: AdEL load, PC freezes, FSM waits
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h33333333, 32'h3102, 32'h0,        32'h3102, 32'h310A, 1, 1, 5'd4, 32'd5,  ST_ERR_WAIT));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h33333333, 32'h3102, 32'h0,        32'h3102, 32'h310A, 0, 0, 5'd0, 32'd5,  ST_ERR_WAIT));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h33333333, 32'h4180, 32'h0,        32'h3102, 32'h310A, 0, 0, 5'd0, 32'd5,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h44444444, 32'h4184, 32'h44444444, 32'h4180, 32'h4188, 1, 0, 5'd0, 32'd6,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h3010,     32'h45454545, 32'h4180, 32'h0,        32'h4180, 32'h4188, 0, 0, 5'd0, 32'd6,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h55555555, 32'h3010, 32'h0,        32'h4180, 32'h4188, 0, 0, 5'd0, 32'd6,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h24000010, 32'h3014, 32'h24000010, 32'h3010, 32'h3018, 1, 0, 5'd0, 32'd7,  ST_RUN));
        // window end 0x5000 is illegal, 0x4FFC is the last legal word
        vecs.push_back(mk(0, 0, 0, 1, 32'h5000,     0, 0, 32'h0,        32'h66666666, 32'h5000, 32'h66666666, 32'h3014, 32'h301C, 1, 0, 5'd0, 32'd8,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h77777777, 32'h5000, 32'h0,        32'h5000, 32'h5008, 1, 1, 5'd4, 32'd8,  ST_ERR_WAIT));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3020,     0, 0, 32'h0,        32'h77777777, 32'h3020, 32'h0,        32'h5000, 32'h5008, 0, 0, 5'd0, 32'd8,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h88888888, 32'h3024, 32'h88888888, 32'h3020, 32'h3028, 1, 0, 5'd0, 32'd9,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h4FFC,     0, 0, 32'h0,        32'h99999999, 32'h4FFC, 32'h99999999, 32'h3024, 32'h302C, 1, 0, 5'd0, 32'd10, ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hAAAAAAAA, 32'h5000, 32'hAAAAAAAA, 32'h4FFC, 32'h5004, 1, 0, 5'd0, 32'd11, ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBBBBBBBB, 32'h5000, 32'h0,        32'h5000, 32'h5008, 1, 1, 5'd4, 32'd11, ST_ERR_WAIT));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBBBBBBBB, 32'h5000, 32'h0,        32'h5000, 32'h5008, 1, 1, 5'd4, 32'd11, ST_ERR_WAIT));
        // reset in ERR_WAIT beats stall and branch
        vecs.push_back(mk(1, 1, 0, 1, 32'h3300,     0, 0, 32'h0,        32'hBBBBBBBB, 32'h3000, 32'h0,        32'h0,    32'h0,    0, 0, 5'd0, 32'd0,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 1, 32'h2FFC,     0, 0, 32'h0,        32'hCCCCCCCC, 32'h2FFC, 32'hCCCCCCCC, 32'h3000, 32'h3008, 1, 0, 5'd0, 32'd1,  ST_RUN));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hCDCDCDCD, 32'h2FFC, 32'h0,        32'h2FFC, 32'h3004, 1, 1, 5'd4, 32'd1,  ST_ERR_WAIT));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h3000,     32'hCDCDCDCD, 32'h3000, 32'h0,        32'h2FFC, 32'h3004, 0, 0, 5'd0, 32'd1,  ST_RUN));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hCECECECE, 32'h3000, 32'h0,        32'h0,    32'h0,    0, 0, 5'd0, 32'd0,  ST_RUN));

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // flush alone, flush under stall, then stall over a bubble, then resume
        run_vec(100, mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'hDDDDDDDD, 32'h3004, 32'hDDDDDDDD, 32'h3000, 32'h3008, 1, 0, 5'd0, 32'd1, ST_RUN));
        run_vec(101, mk(0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'hDEDEDEDE, 32'h3008, 32'h0,        32'h3000, 32'h3008, 0, 0, 5'd0, 32'd1, ST_RUN));
        run_vec(102, mk(0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 32'hDFDFDFDF, 32'h3008, 32'h0,        32'h3000, 32'h3008, 0, 0, 5'd0, 32'd1, ST_RUN));
        run_vec(103, mk(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'hEEEEEEEE, 32'h3008, 32'h0,        32'h3000, 32'h3008, 0, 0, 5'd0, 32'd1, ST_RUN));
        run_vec(104, mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'hEEEEEEEE, 32'h300C, 32'hEEEEEEEE, 32'h3008, 32'h3010, 1, 0, 5'd0, 32'd2, ST_RUN));

        // exc_req under stall still redirects out of a fresh error wait
        run_vec(105, mk(0, 0, 0, 1, 32'h3006, 0, 0, 32'h0, 32'h12121212, 32'h3006, 32'h12121212, 32'h300C, 32'h3014, 1, 0, 5'd0, 32'd3, ST_RUN));
        run_vec(106, mk(0, 0, 0, 0, 32'h0,    0, 0, 32'h0, 32'h13131313, 32'h3006, 32'h0,        32'h3006, 32'h300E, 1, 1, 5'd4, 32'd3, ST_ERR_WAIT));
        run_vec(107, mk(0, 1, 0, 0, 32'h0,    1, 0, 32'h0, 32'h13131313, 32'h4180, 32'h0,        32'h3006, 32'h300E, 0, 0, 5'd0, 32'd3, ST_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter HANDLER_PC, 32'h0000_4180, exception entry address (instruction-memory word 1120).
REQ-003 Parameter IM_WORDS, 2048, instruction-memory depth; the legal fetch window is [PC_RESET, PC_RESET+4*IM_WORDS).
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port stall, input, 1, hazard-unit freeze of the PC and the IF/ID register.
REQ-007 Port flush, input, 1, inserts a bubble into IF/ID.
REQ-008 Port br_taken, input, 1, branch/jump redirect valid.
REQ-009 Port br_target, input, 32, redirect address.
REQ-010 Port exc_req, input, 1, exception taken by CP0.
REQ-011 Port eret, input, 1, return from exception.
REQ-012 Port epc, input, 32, eret return address.
REQ-013 Port im_addr, output, 32, current PC, driven to the instruction memory.
REQ-014 Port im_data, input, 32, combinational instruction-memory read data for im_addr.
REQ-015 Port instr_D / pc_D / pc8_D, output, 32 each, IF/ID instruction, PC and PC+8.
REQ-016 Port valid_D, output, 1, the IF/ID register holds a real instruction.
REQ-017 Port exc_D, output, 1, fetch address error; exccode_D, output, 5, 5'd4 (AdEL) when exc_D=1, else 0.
REQ-018 Port fetch_count, output, 32, count of good instructions loaded into IF/ID.

Function
REQ-019 im_addr SHALL equal the PC register combinationally.
REQ-020 Next-PC priority SHALL be: reset > exc_req (HANDLER_PC) > eret (epc) > br_taken (br_target) > stall (hold) > PC+4.
- exc_req and eret override stall.
- exc_req together with eret: exc_req wins.
REQ-021 Address error SHALL be detected when PC[1:0]!=0 or the PC lies outside the legal window.
REQ-022 IF/ID update rules, evaluated each edge in priority order:
- exc_req, eret or flush: load a bubble (instr_D=0, valid_D=0, exc_D=0, exccode_D=0), even if stall is also high.
- stall: hold all IF/ID outputs.
- address error: load instr_D=0, pc_D=PC, pc8_D=PC+8, valid_D=1, exc_D=1, exccode_D=5'd4.
- otherwise: load instr_D=im_data, pc_D=PC, pc8_D=PC+8, valid_D=1, exc_D=0.
REQ-023 Latency SHALL be one cycle: an instruction at PC appears on instr_D on the edge after which PC is presented.
REQ-024 FSM states SHALL be RUN and ERR_WAIT.
- RUN -> ERR_WAIT when an address-error fetch is loaded into IF/ID.
- ERR_WAIT -> RUN on exc_req, eret or br_taken, with the PC loaded per REQ-020.
REQ-025 In ERR_WAIT the PC SHALL hold, and each non-stalled edge SHALL load a bubble into IF/ID.
REQ-026 A br_taken arriving in ERR_WAIT SHALL cancel the pending error, because the error was on a wrong path.
REQ-027 fetch_count SHALL increment by 1 per good load (REQ-022, last case) and wrap modulo 2^32.
REQ-028 PC+4 and PC+8 SHALL be 32-bit sums that wrap silently; a wrapped PC is flagged by REQ-021.

Reset
REQ-029 On a reset edge the block SHALL set PC=PC_RESET and state=RUN.
REQ-030 On a reset edge the block SHALL set instr_D=0, pc_D=0, pc8_D=0, valid_D=0, exc_D=0, exccode_D=0, fetch_count=0.
REQ-031 Reset SHALL override every other input, including reset mid-stall and reset in ERR_WAIT.

Structure
REQ-032 PC_RESET, HANDLER_PC, the ExcCode constants (AdEL=4) and the state encoding SHALL live in the shared CPU definitions package.
REQ-033 The IF/ID pipeline register SHALL be one sub-module, if_id_reg, with load, hold and bubble controls; the PC, FSM and counter stay in fetch_ctrl.

Verification
REQ-034 Scenario: release reset, no stalls, 4 cycles with im_data=0x2400000N -> pc_D=0x3000, 0x3004, 0x3008, 0x300C; fetch_count=4.
REQ-035 Scenario: stall for 2 cycles at PC 0x3008 -> im_addr held at 0x3008; instr_D and pc_D unchanged; fetch_count unchanged.
REQ-036 Scenario: br_taken=1 with br_target=0x3100 and stall=1 -> next im_addr=0x3100.
REQ-037 Scenario: flush together with br_taken -> valid_D=0 on that edge.
REQ-038 Scenario: br_target=0x3102 -> next load gives exc_D=1, exccode_D=4, pc_D=0x3102; the PC holds.
- Next cycle, exc_req -> im_addr=0x4180, state=RUN.
REQ-039 Scenario: exc_req and eret in the same cycle -> im_addr=0x4180.
REQ-040 Scenario: eret with epc=0x3010 -> im_addr=0x3010 and valid_D=0.
REQ-041 Scenario: reset asserted in ERR_WAIT -> all REQ-029/REQ-030 values after one edge.
